// File: rtl/ahb_slave_if_gen.sv
// AHB-Lite slave front end for the AHB-to-APB bridge: transfer qualification,
// one-hot APB region decode, stall-aware address/data/direction delay pipeline
// and HREADYOUT/HRESP generation.
// Define AHB_SLV_ERRRESP_EN to enable the two-cycle ERROR response for
// out-of-range accesses; without it every response is OKAY.
module ahb_slave_if_gen #(
   parameter int unsigned          ADDR_W      = 32,
   parameter int unsigned          DATA_W      = 32,
   parameter int unsigned          NUM_SLV     = 3,
   parameter logic [ADDR_W-1:0]    BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned          REGION_LOG2 = 26,
   parameter int unsigned          PIPE_DEPTH  = 2
) (
   input  logic                         hclk,
   input  logic                         hreset,
   input  logic                         hwrite,
   input  logic                         hready_in,
   input  logic [1:0]                   htrans,
   input  logic [ADDR_W-1:0]            haddr,
   input  logic [DATA_W-1:0]            hwdata,
   input  logic                         stall_in,
   input  logic [DATA_W-1:0]            prdata,
   output logic                         valid,
   output logic [NUM_SLV-1:0]           selx,
   output logic [PIPE_DEPTH*ADDR_W-1:0] haddr_pipe,
   output logic [PIPE_DEPTH*DATA_W-1:0] hwdata_pipe,
   output logic [PIPE_DEPTH-1:0]        hwrite_pipe,
   output logic                         hready_out,
   output logic [1:0]                   hresp,
   output logic [DATA_W-1:0]            hrdata
);

   localparam logic [1:0] RespOkay = 2'b00;
   localparam logic [1:0] RespErr  = 2'b01;

   // One extra bit so the region upper bound cannot wrap past the address space.
   localparam logic [ADDR_W:0] BaseExt  = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0] LimitExt = BaseExt + ((ADDR_W+1)'(NUM_SLV) << REGION_LOG2);

   logic              active;
   logic              hit;
   logic [ADDR_W:0]   addr_ext;
   logic [ADDR_W:0]   region;

   logic [PIPE_DEPTH*ADDR_W-1:0] haddr_pipe_d, haddr_pipe_q;
   logic [PIPE_DEPTH*DATA_W-1:0] hwdata_pipe_d, hwdata_pipe_q;
   logic [PIPE_DEPTH-1:0]        hwrite_pipe_d, hwrite_pipe_q;

   assign active = hready_in & htrans[1];
   assign valid  = active & hit;
   assign hrdata = prdata;

   // Range check and one-hot region decode (independent of htrans).
   always_comb begin
      addr_ext = {1'b0, haddr};
      hit      = (addr_ext >= BaseExt) && (addr_ext < LimitExt);
      region   = (addr_ext - BaseExt) >> REGION_LOG2;
      selx     = '0;
      for (int i = 0; i < int'(NUM_SLV); i++) begin
         selx[i] = hit && (region == (ADDR_W+1)'(i));
      end
   end

   // Pipeline next state: shift on an accepted edge, hold while HREADY is low.
   always_comb begin
      haddr_pipe_d  = haddr_pipe_q;
      hwdata_pipe_d = hwdata_pipe_q;
      hwrite_pipe_d = hwrite_pipe_q;
      if (hready_in) begin
         haddr_pipe_d[0 +: ADDR_W]  = haddr;
         hwdata_pipe_d[0 +: DATA_W] = hwdata;
         hwrite_pipe_d[0]           = hwrite;
         for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
            haddr_pipe_d[k*ADDR_W +: ADDR_W]  = haddr_pipe_q[(k-1)*ADDR_W +: ADDR_W];
            hwdata_pipe_d[k*DATA_W +: DATA_W] = hwdata_pipe_q[(k-1)*DATA_W +: DATA_W];
            hwrite_pipe_d[k]                  = hwrite_pipe_q[k-1];
         end
      end
   end

   // Pipeline registers.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         haddr_pipe_q  <= '0;
         hwdata_pipe_q <= '0;
         hwrite_pipe_q <= '0;
      end else begin
         haddr_pipe_q  <= haddr_pipe_d;
         hwdata_pipe_q <= hwdata_pipe_d;
         hwrite_pipe_q <= hwrite_pipe_d;
      end
   end

   assign haddr_pipe  = haddr_pipe_q;
   assign hwdata_pipe = hwdata_pipe_q;
   assign hwrite_pipe = hwrite_pipe_q;

`ifdef AHB_SLV_ERRRESP_EN
   typedef enum logic [1:0] {StOkay, StErr1, StErr2} state_e;

   state_e state_d, state_q;
   logic   miss;

   assign miss = active & ~hit;

   // Response FSM: a miss yields one wait cycle then one ready cycle of ERROR.
   always_comb begin
      state_d    = state_q;
      hready_out = ~stall_in;
      hresp      = RespOkay;
      unique case (state_q)
         StOkay: begin
            if (miss) state_d = StErr1;
         end
         StErr1: begin
            hready_out = 1'b0;
            hresp      = RespErr;
            state_d    = StErr2;
         end
         StErr2: begin
            hready_out = 1'b1;
            hresp      = RespErr;
            state_d    = miss ? StErr1 : StOkay;
         end
         default: state_d = StOkay;
      endcase
      // Reset forces a ready OKAY immediately, even mid-error or while stalled.
      if (hreset) begin
         hready_out = 1'b1;
         hresp      = RespOkay;
      end
   end

   // Response state register.
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) state_q <= StOkay;
      else        state_q <= state_d;
   end
`else
   // Without error responses every transfer is OKAY; only the controller stalls.
   always_comb begin
      hready_out = hreset ? 1'b1 : ~stall_in;
      hresp      = RespOkay;
   end
`endif

endmodule

// File: tb/tb_ahb_slave_if_gen.sv
// Directed self-checking bench for ahb_slave_if_gen (default parameters).
// Error-response expectations follow AHB_SLV_ERRRESP_EN as defined for the build.
`timescale 1ns/1ps
module tb_ahb_slave_if_gen;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        hwrite;
   logic        hready_in;
   logic        hready_in_drv;
   logic        tie;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        stall_in;
   logic [31:0] prdata;
   logic        valid;
   logic [2:0]  selx;
   logic [63:0] haddr_pipe;
   logic [63:0] hwdata_pipe;
   logic [1:0]  hwrite_pipe;
   logic        hready_out;
   logic [1:0]  hresp;
   logic [31:0] hrdata;

   int tests = 0;
   int fails = 0;

   always #5 hclk = ~hclk;

   assign hready_in = tie ? hready_out : hready_in_drv;

   ahb_slave_if_gen dut (
      .hclk        (hclk),
      .hreset      (hreset),
      .hwrite      (hwrite),
      .hready_in   (hready_in),
      .htrans      (htrans),
      .haddr       (haddr),
      .hwdata      (hwdata),
      .stall_in    (stall_in),
      .prdata      (prdata),
      .valid       (valid),
      .selx        (selx),
      .haddr_pipe  (haddr_pipe),
      .hwdata_pipe (hwdata_pipe),
      .hwrite_pipe (hwrite_pipe),
      .hready_out  (hready_out),
      .hresp       (hresp),
      .hrdata      (hrdata)
   );

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic test_reset();
      hreset = 1'b1; stall_in = 1'b1;
      step();
      #1;
      tests++;
      if (hready_out !== 1'b1) begin
         fails++; $display("FAIL reset_hready: got %b want 1", hready_out);
      end
      tests++;
      if (hresp !== 2'b00) begin
         fails++; $display("FAIL reset_hresp: got %b want 00", hresp);
      end
      tests++;
      if (haddr_pipe !== 64'h0 || hwdata_pipe !== 64'h0 || hwrite_pipe !== 2'b00) begin
         fails++; $display("FAIL reset_pipes: got %h %h %b want 0", haddr_pipe, hwdata_pipe,
                           hwrite_pipe);
      end
      stall_in = 1'b0;
      hreset = 1'b0;
      step();
   endtask

   task automatic test_write_read_hit();
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8000_0010; hwdata = 32'h1234_5678;
      #1;
      tests++;
      if (valid !== 1'b1 || selx !== 3'b001) begin
         fails++; $display("FAIL wr_decode: got valid=%b selx=%b want 1 001", valid, selx);
      end
      step();
      // Next address phase: SEQ read in region 1
      htrans = 2'b11; hwrite = 1'b0; haddr = 32'h8400_0004; hwdata = 32'h0; prdata = 32'hDEAD_BEEF;
      #1;
      tests++;
      if (haddr_pipe[31:0] !== 32'h8000_0010 || hwdata_pipe[31:0] !== 32'h1234_5678
          || hwrite_pipe[0] !== 1'b1) begin
         fails++; $display("FAIL wr_stage0: got %h %h %b want 80000010 12345678 1",
                           haddr_pipe[31:0], hwdata_pipe[31:0], hwrite_pipe[0]);
      end
      tests++;
      if (valid !== 1'b1 || selx !== 3'b010 || hrdata !== 32'hDEAD_BEEF || hresp !== 2'b00
          || hready_out !== 1'b1) begin
         fails++; $display("FAIL rd_decode: got v=%b selx=%b hrdata=%h hresp=%b rdy=%b",
                           valid, selx, hrdata, hresp, hready_out);
      end
      step();
      htrans = 2'b00;
      #1;
      tests++;
      if (haddr_pipe !== {32'h8000_0010, 32'h8400_0004} || hwrite_pipe !== 2'b10
          || hwdata_pipe[63:32] !== 32'h1234_5678) begin
         fails++; $display("FAIL wr_stage1: got %h %b want 8000001084000004 10",
                           haddr_pipe, hwrite_pipe);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] addrs [3];
      addrs[0] = 32'h7FFF_FFFC; addrs[1] = 32'hFFFF_FFFF; addrs[2] = 32'h8BFF_FFFF;
      htrans = 2'b00;
      for (int i = 0; i < 3; i++) begin
         haddr = addrs[i];
         #1;
         tests++;
         if (selx !== ((i == 2) ? 3'b100 : 3'b000)) begin
            fails++; $display("FAIL range_edge%0d: got selx=%b", i, selx);
         end
      end
      step();
   endtask

   task automatic test_miss();
      logic [1:0] exp_resp [3];
      logic       exp_rdy  [3];
`ifdef AHB_SLV_ERRRESP_EN
      exp_resp[0] = 2'b01; exp_rdy[0] = 1'b0;
      exp_resp[1] = 2'b01; exp_rdy[1] = 1'b1;
`else
      exp_resp[0] = 2'b00; exp_rdy[0] = 1'b1;
      exp_resp[1] = 2'b00; exp_rdy[1] = 1'b1;
`endif
      exp_resp[2] = 2'b00; exp_rdy[2] = 1'b1;
      htrans = 2'b10; haddr = 32'h8C00_0000;
      #1;
      tests++;
      if (valid !== 1'b0 || selx !== 3'b000 || hresp !== 2'b00 || hready_out !== 1'b1) begin
         fails++; $display("FAIL miss_addr: got v=%b selx=%b hresp=%b rdy=%b",
                           valid, selx, hresp, hready_out);
      end
      step();
      htrans = 2'b00;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (hresp !== exp_resp[i] || hready_out !== exp_rdy[i]) begin
            fails++; $display("FAIL miss_resp%0d: got hresp=%b rdy=%b want %b %b", i, hresp,
                              hready_out, exp_resp[i], exp_rdy[i]);
         end
         step();
      end
   endtask

`ifdef AHB_SLV_ERRRESP_EN
   task automatic test_err_back_to_back();
      htrans = 2'b10; haddr = 32'h8C00_0000;
      step();
      htrans = 2'b00;
      step();
      // ERR2: master does not cancel, issues another miss
      htrans = 2'b10; haddr = 32'hC000_0000;
      step();
      htrans = 2'b00;
      #1;
      tests++;
      if (hresp !== 2'b01 || hready_out !== 1'b0) begin
         fails++; $display("FAIL err2_to_err1: got hresp=%b rdy=%b want 01 0", hresp, hready_out);
      end
      step();
      // ERR2 with a hit in the address phase
      htrans = 2'b10; haddr = 32'h8000_0008;
      #1;
      tests++;
      if (valid !== 1'b1 || hresp !== 2'b01 || hready_out !== 1'b1) begin
         fails++; $display("FAIL err2_hit: got v=%b hresp=%b rdy=%b want 1 01 1",
                           valid, hresp, hready_out);
      end
      step();
      htrans = 2'b00;
      #1;
      tests++;
      if (hresp !== 2'b00 || haddr_pipe[31:0] !== 32'h8000_0008) begin
         fails++; $display("FAIL err2_hit_after: got hresp=%b s0=%h want 00 80000008",
                           hresp, haddr_pipe[31:0]);
      end
      step();
   endtask
`endif

   task automatic test_stall();
      tie = 1'b0; hready_in_drv = 1'b1;
      htrans = 2'b00; haddr = 32'h8000_0040;
      step();
      htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8800_0020; hwdata = 32'hCAFE_0001;
      #1;
      tests++;
      if (valid !== 1'b1 || selx !== 3'b100) begin
         fails++; $display("FAIL stall_hit: got v=%b selx=%b want 1 100", valid, selx);
      end
      step();
      tie = 1'b1; stall_in = 1'b1;
      haddr = 32'h8000_0100; hwdata = 32'hCAFE_0002; hwrite = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++;
         if (hready_out !== 1'b0 || haddr_pipe !== {32'h8000_0040, 32'h8800_0020}
             || hwdata_pipe[31:0] !== 32'hCAFE_0001) begin
            fails++; $display("FAIL stall_hold%0d: got rdy=%b pipe=%h", i, hready_out,
                              haddr_pipe);
         end
         step();
      end
      stall_in = 1'b0;
      #1;
      tests++;
      if (hready_out !== 1'b1) begin
         fails++; $display("FAIL stall_release: got rdy=%b want 1", hready_out);
      end
      step();
      htrans = 2'b00;
      #1;
      tests++;
      if (haddr_pipe !== {32'h8800_0020, 32'h8000_0100} || hwrite_pipe !== 2'b10) begin
         fails++; $display("FAIL stall_advance: got %h %b want 8800002080000100 10",
                           haddr_pipe, hwrite_pipe);
      end
      tie = 1'b0;
   endtask

   task automatic test_busy();
      htrans = 2'b01; haddr = 32'h8000_0000;
      #1;
      tests++;
      if (valid !== 1'b0 || selx !== 3'b001 || hready_out !== 1'b1 || hresp !== 2'b00) begin
         fails++; $display("FAIL busy: got v=%b selx=%b rdy=%b hresp=%b want 0 001 1 00",
                           valid, selx, hready_out, hresp);
      end
      step();
      #1;
      tests++;
      if (hresp !== 2'b00 || hready_out !== 1'b1) begin
         fails++; $display("FAIL busy_resp: got hresp=%b rdy=%b want 00 1", hresp, hready_out);
      end
   endtask

   task automatic test_reset_in_err();
      htrans = 2'b10; haddr = 32'h9000_0000;
      step();
      htrans = 2'b00;
      #1;
`ifdef AHB_SLV_ERRRESP_EN
      tests++;
      if (hready_out !== 1'b0 || hresp !== 2'b01) begin
         fails++; $display("FAIL err1_entry: got rdy=%b hresp=%b want 0 01", hready_out, hresp);
      end
`endif
      #2;
      hreset = 1'b1;
      #1;
      tests++;
      if (hready_out !== 1'b1 || hresp !== 2'b00 || haddr_pipe !== 64'h0
          || hwdata_pipe !== 64'h0 || hwrite_pipe !== 2'b00) begin
         fails++; $display("FAIL reset_abort: got rdy=%b hresp=%b pipe=%h", hready_out, hresp,
                           haddr_pipe);
      end
      step();
      hreset = 1'b0;
      step();
      #1;
      tests++;
      if (hready_out !== 1'b1 || hresp !== 2'b00) begin
         fails++; $display("FAIL after_reset: got rdy=%b hresp=%b want 1 00", hready_out, hresp);
      end
   endtask

   initial begin
      hreset = 1'b1; hwrite = 1'b0; hready_in_drv = 1'b1; tie = 1'b0; htrans = 2'b00;
      haddr = 32'h0; hwdata = 32'h0; stall_in = 1'b0; prdata = 32'h0;
      test_reset();
      test_write_read_hit();
      test_out_of_range();
      test_miss();
`ifdef AHB_SLV_ERRRESP_EN
      test_err_back_to_back();
`endif
      test_stall();
      test_busy();
      test_reset_in_err();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
